// File: rtl/adc_scan_scheduler.sv
// Burst scheduler and averager for an MCP3008 X/Y joystick driver.
// Define DEADZONE_EN to add registered direction flags derived from each new average.
module adc_scan_scheduler #(
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned AVG_SHIFT     = 2,
  parameter int unsigned TIMEOUT       = 2048,
  parameter int unsigned CENTER        = 512,
  parameter int unsigned DEADZONE      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       req,
  output logic       ack,
  output logic       adc_start,
  input  logic [9:0] adc_x,
  input  logic [9:0] adc_y,
  input  logic       adc_valid,
  output logic [9:0] x_avg,
  output logic [9:0] y_avg,
  output logic       avg_valid,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
`ifdef DEADZONE_EN
  ,
  output logic       dir_left,
  output logic       dir_right,
  output logic       dir_down,
  output logic       dir_up
`endif
);

  localparam int unsigned AccW  = 10 + AVG_SHIFT;
  localparam int unsigned CntW  = AVG_SHIFT + 1;
  localparam int unsigned TmrW  = $clog2(SAMPLE_PERIOD);
  localparam int unsigned WdW   = $clog2(TIMEOUT + 1);
  localparam int unsigned Burst = 1 << AVG_SHIFT;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StAccum, StDone} state_e;

  state_e          state_q;
  logic [TmrW-1:0] timer_q;
  logic            tick_pend_q;
  logic            src_req_q;
  logic [AccW-1:0] acc_x_q, acc_y_q;
  logic [CntW-1:0] cnt_q;
  logic [WdW-1:0]  wd_q;
  logic            tick_tc, tick_take;
  logic [9:0]      x_new, y_new;

  assign tick_tc   = (timer_q == TmrW'(SAMPLE_PERIOD - 1));
  assign tick_take = (state_q == StIdle) && !req && tick_pend_q;
  assign x_new     = acc_x_q[AVG_SHIFT +: 10];
  assign y_new     = acc_y_q[AVG_SHIFT +: 10];
  assign busy      = (state_q != StIdle);

  // Depth-1 tick pending flag; a new tick on the consume cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      timer_q     <= '0;
      tick_pend_q <= 1'b0;
    end else begin
      timer_q <= tick_tc ? '0 : timer_q + TmrW'(1);
      if (tick_tc) tick_pend_q <= 1'b1;
      else if (tick_take) tick_pend_q <= 1'b0;
    end
  end

`ifdef DEADZONE_EN
  localparam int DzLo = int'(CENTER) - int'(DEADZONE);
  localparam int DzHi = int'(CENTER) + int'(DEADZONE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      src_req_q   <= 1'b0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      ack         <= 1'b0;
      adc_start   <= 1'b0;
      avg_valid   <= 1'b0;
      x_avg       <= '0;
      y_avg       <= '0;
      timeout_err <= 1'b0;
`ifdef DEADZONE_EN
      dir_left    <= 1'b0;
      dir_right   <= 1'b0;
      dir_down    <= 1'b0;
      dir_up      <= 1'b0;
`endif
    end else begin
      ack       <= 1'b0;
      adc_start <= 1'b0;
      avg_valid <= 1'b0;
      // A timeout below overrides this clear in the same cycle.
      if (err_clr) timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req || tick_pend_q) begin
            src_req_q <= req;
            adc_start <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          wd_q    <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (adc_valid) begin
            acc_x_q <= acc_x_q + AccW'(adc_x);
            acc_y_q <= acc_y_q + AccW'(adc_y);
            cnt_q   <= cnt_q + CntW'(1);
            state_q <= StAccum;
          end else if (wd_q == WdW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            cnt_q       <= '0;
            ack         <= src_req_q;
            state_q     <= StIdle;
          end else begin
            wd_q <= wd_q + WdW'(1);
          end
        end
        StAccum: begin
          if (cnt_q < CntW'(Burst)) begin
            adc_start <= 1'b1;
            state_q   <= StIssue;
          end else begin
            // Results land in the DONE cycle so ack and avg_valid coincide with them.
            x_avg     <= x_new;
            y_avg     <= y_new;
            avg_valid <= 1'b1;
            ack       <= src_req_q;
`ifdef DEADZONE_EN
            dir_left  <= int'({22'd0, x_new}) < DzLo;
            dir_right <= int'({22'd0, x_new}) > DzHi;
            dir_down  <= int'({22'd0, y_new}) < DzLo;
            dir_up    <= int'({22'd0, y_new}) > DzHi;
`endif
            state_q   <= StDone;
          end
        end
        StDone: begin
          acc_x_q <= '0;
          acc_y_q <= '0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler with a behavioural MCP3008 responder.
// Define DEADZONE_EN for both files to exercise the direction flags.
module tb_adc_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst, enable, req, err_clr;
  logic       ack, adc_start, adc_valid, avg_valid, busy, timeout_err;
  logic [9:0] adc_x, adc_y, x_avg, y_avg;
`ifdef DEADZONE_EN
  logic dir_left, dir_right, dir_down, dir_up;
  logic [3:0] last_dir;
`endif

  always #5 clk = ~clk;

  adc_scan_scheduler #(
    .SAMPLE_PERIOD(16),
    .AVG_SHIFT    (2),
    .TIMEOUT      (32),
    .CENTER       (512),
    .DEADZONE     (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req        (req),
    .ack        (ack),
    .adc_start  (adc_start),
    .adc_x      (adc_x),
    .adc_y      (adc_y),
    .adc_valid  (adc_valid),
    .x_avg      (x_avg),
    .y_avg      (y_avg),
    .avg_valid  (avg_valid),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
`ifdef DEADZONE_EN
    ,
    .dir_left   (dir_left),
    .dir_right  (dir_right),
    .dir_down   (dir_down),
    .dir_up     (dir_up)
`endif
  );

  int checks = 0;
  int failures = 0;
  int n_start = 0, n_avg = 0, n_ack = 0, n_coinc = 0;
  logic [9:0] last_x, last_y;
  logic [9:0] exp_last_x = 10'd0;

  // Responder: returns one queued sample 'lat' cycles after each start pulse.
  logic [9:0] xq[$], yq[$];
  bit respond = 1'b1;
  int lat = 2;
  int pend = 0;
  logic [9:0] nx, ny;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial begin
    adc_valid = 1'b0;
    adc_x = '0;
    adc_y = '0;
    forever begin
      @(negedge clk);
      adc_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_valid = 1'b1;
          adc_x = nx;
          adc_y = ny;
        end
      end
      if (adc_start && respond) begin
        nx = (xq.size() > 0) ? xq.pop_front() : 10'd0;
        ny = (yq.size() > 0) ? yq.pop_front() : 10'd0;
        pend = lat;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (adc_start) n_start++;
      if (ack) n_ack++;
      if (avg_valid) begin
        n_avg++;
        last_x = x_avg;
        last_y = y_avg;
`ifdef DEADZONE_EN
        last_dir = {dir_left, dir_right, dir_down, dir_up};
`endif
      end
      if (ack && avg_valid) n_coinc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  // One full burst from either source; expectations come from the caller.
  task automatic run_burst(input string nm, input bit use_req, input logic [3:0][9:0] xs,
                           input logic [3:0][9:0] ys, input logic [9:0] ex, input logic [9:0] ey);
    int s0, a0, k0, c0;
    bit seen;
    for (int i = 0; i < 4; i++) begin
      xq.push_back(xs[i]);
      yq.push_back(ys[i]);
    end
    s0 = n_start; a0 = n_avg; k0 = n_ack; c0 = n_coinc;
    seen = 1'b0;
    if (use_req) req = 1'b1;
    else enable = 1'b1;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (avg_valid) seen = 1'b1;
    end
    req = 1'b0;
    enable = 1'b0;
    check({nm, "_done"}, 32'(seen), 32'd1);
    repeat (12) @(negedge clk);
    check({nm, "_starts"}, n_start - s0, 32'd4);
    check({nm, "_avgs"}, n_avg - a0, 32'd1);
    check({nm, "_acks"}, n_ack - k0, 32'(use_req));
    check({nm, "_coinc"}, n_coinc - c0, 32'(use_req));
    check({nm, "_x"}, 32'(last_x), 32'(ex));
    check({nm, "_y"}, 32'(last_y), 32'(ey));
    exp_last_x = ex;
  endtask

  typedef struct {
    string      nm;
    bit         use_req;
    logic [9:0] x0, xs, y0, ys, ex, ey;
  } vec_t;
  vec_t vecs[4];

  logic [3:0][9:0] bx, by;
  int sx, sy, a0, k0, s0;
  bit found;

  initial begin
    vecs[0] = '{"tick_ramp", 1'b0, 10'd100, 10'd4, 10'd0, 10'd0, 10'd106, 10'd0};
    vecs[1] = '{"req_full", 1'b1, 10'd1023, 10'd0, 10'd1023, 10'd0, 10'd1023, 10'd1023};
    vecs[2] = '{"req_small", 1'b1, 10'd0, 10'd1, 10'd7, 10'd3, 10'd1, 10'd11};
    vecs[3] = '{"tick_trunc", 1'b0, 10'd1000, 10'd7, 10'd5, 10'd0, 10'd1010, 10'd5};

    rst = 1'b1; enable = 1'b0; req = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(adc_start), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_avgv", 32'(avg_valid), 32'd0);
    check("rst_avg", 32'({x_avg, y_avg}), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_no_start", n_start, 32'd0);

    foreach (vecs[v]) begin
      for (int i = 0; i < 4; i++) begin
        bx[i] = vecs[v].x0 + 10'(i) * vecs[v].xs;
        by[i] = vecs[v].y0 + 10'(i) * vecs[v].ys;
      end
      run_burst(vecs[v].nm, vecs[v].use_req, bx, by, vecs[v].ex, vecs[v].ey);
    end

    for (int n = 0; n < 20; n++) begin
      sx = 0; sy = 0;
      for (int i = 0; i < 4; i++) begin
        bx[i] = 10'($urandom_range(0, 1023));
        by[i] = 10'($urandom_range(0, 1023));
        sx += int'(bx[i]);
        sy += int'(by[i]);
      end
      lat = $urandom_range(1, 5);
      run_burst("rand", 1'($urandom_range(0, 1)), bx, by, 10'(sx / 4), 10'(sy / 4));
    end
    lat = 2;

    // Tick and req coincide in one IDLE cycle: req is served first, tick right after.
    xq.delete(); yq.delete();
    for (int i = 0; i < 8; i++) begin
      xq.push_back(i < 4 ? 10'd200 : 10'd40);
      yq.push_back(10'd300);
    end
    a0 = n_avg; k0 = n_ack;
    enable = 1'b1;
    repeat (16) @(negedge clk);
    req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (ack) found = 1'b1;
    end
    req = 1'b0;
    check("both_ack", 32'(found), 32'd1);
    check("both_req_first", n_avg - a0, 32'd1);
    check("both_req_x", 32'(x_avg), 32'd200);
    @(negedge clk);
    check("both_gap_idle", 32'({busy, adc_start}), 32'd0);
    @(negedge clk);
    check("both_tick_start", 32'(adc_start), 32'd1);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    check("both_avgs", n_avg - a0, 32'd2);
    check("both_acks", n_ack - k0, 32'd1);
    check("both_tick_x", 32'(last_x), 32'd40);
    exp_last_x = 10'd40;

    // Stalled driver, tick-sourced: no ack, averages untouched.
    respond = 1'b0;
    a0 = n_avg; k0 = n_ack;
    enable = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (adc_start) found = 1'b1;
    end
    enable = 1'b0;
    check("to_start", 32'(found), 32'd1);
    repeat (32) @(negedge clk);
    check("to_pre", 32'({busy, timeout_err}), 32'b10);
    @(negedge clk);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_xavg", 32'(x_avg), 32'(exp_last_x));
    repeat (3) @(negedge clk);
    check("to_no_avg", n_avg - a0, 32'd0);
    check("to_no_ack", n_ack - k0, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_clr", 32'(timeout_err), 32'd0);

    // Stalled driver, req-sourced, with err_clr high on the timeout cycle.
    req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (adc_start) found = 1'b1;
    end
    check("tor_start", 32'(found), 32'd1);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 30) err_clr = 1'b1;
    end
    check("tor_pre", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("tor_err_wins", 32'(timeout_err), 32'd1);
    check("tor_ack", 32'(ack), 32'd1);
    req = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("tor_no_avg", n_avg - a0, 32'd0);
    respond = 1'b1;

    // Reset during WAIT; the late result must be ignored.
    xq.delete(); yq.delete();
    xq.push_back(10'd321); yq.push_back(10'd123);
    lat = 6;
    req = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (adc_start) found = 1'b1;
    end
    check("rw_start", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    check("rw_outs", 32'({busy, adc_start, ack, avg_valid, timeout_err}), 32'd0);
    check("rw_avg", 32'({x_avg, y_avg}), 32'd0);
    rst = 1'b0;
    a0 = n_avg; s0 = n_start;
    repeat (12) @(negedge clk);
    check("rw_no_avg", n_avg - a0, 32'd0);
    check("rw_no_start", n_start - s0, 32'd0);
    check("rw_hold", 32'({busy, x_avg}), 32'd0);
    lat = 2;

`ifdef DEADZONE_EN
    for (int i = 0; i < 4; i++) begin
      bx[i] = 10'd400;
      by[i] = 10'd600;
    end
    run_burst("dz", 1'b1, bx, by, 10'd400, 10'd600);
    check("dz_flags", 32'(last_dir), 32'b1001);
    for (int i = 0; i < 4; i++) begin
      bx[i] = 10'd700;
      by[i] = 10'd448;
    end
    run_burst("dz2", 1'b0, bx, by, 10'd700, 10'd448);
    check("dz2_flags", 32'(last_dir), 32'b0100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
